dot_product_accumulator: RTL and testbench
==========================================

// Module: dot_product_accumulator
// PURPOSE
//  Downstream consumer of the MultiplyAdd chain in the dot-product datapath. Collects
//  the chain's RES stream (qualified by its outReady), sums LEN consecutive partial
//  results into one dot product, and holds the result until the next stage acknowledges.
//  Adds frame counting, result hand-off with overrun detection, and optional saturation.
// PARAMETERS
//  IN_WIDTH   21  width of signed partial result from the MultiplyAdd stage
//  OUT_WIDTH  26  width of signed accumulated result; must be >= IN_WIDTH
//  LEN        16  partial results per frame; must be >= 1; counter width = $clog2(LEN+1)
// PORTS
//  clk       in   1          rising-edge clock
//  reset     in   1          asynchronous, active-high reset
//  enable    in   1          clock enable; low freezes all state (reset still acts)
//  clear     in   1          synchronous frame abort; discards the partial sum
//  inReady   in   1          inData valid this cycle (driven by MultiplyAdd outReady)
//  inData    in   IN_WIDTH   signed partial result (MultiplyAdd RES)
//  outAck    in   1          consumer accepts the held result
//  outReady  out  1          held result valid; stays high until acked
//  RES       out  OUT_WIDTH  signed dot-product result
//  busy      out  1          frame in progress (state ACCUM)
//  overrun   out  1          sticky: an unacked result was overwritten
//  sat       out  1          sticky: saturation occurred (macro builds only; else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE, count=0, acc=0, RES=0, outReady=0, overrun=0, sat=0.
//  - Outputs are registered. All state advances only when enable=1; outAck is ignored
//    while enable=0.
//  - inData is sign-extended to OUT_WIDTH before any add.
//  - FSM IDLE: on inReady, acc<=inData (load, no add), count<=1, go to ACCUM.
//    If LEN==1, complete the frame instead and stay in IDLE.
//  - FSM ACCUM: on inReady, acc<=acc+inData and count++. The sample where count==LEN-1
//    completes the frame: RES<=acc+inData, outReady<=1, count<=0, go to IDLE.
//    Gaps (inReady=0) hold everything.
//  - Latency: outReady and RES are valid on the cycle after the last sample's edge.
//    Back-to-back frames are supported with no idle cycle.
//  - Hand-off: outAck with outReady=1 clears outReady next cycle. RES holds its last value.
//  - Frame completes while outReady=1:
//    - If outAck is also high the same cycle: the new result loads, outReady stays 1,
//      and there is no overrun.
//    - Otherwise: RES is overwritten, outReady stays 1, and overrun<=1.
//  - clear: count<=0, acc<=0, go to IDLE; any inReady sample that cycle is dropped.
//    clear does not touch outReady, RES, overrun, or sat. clear outranks frame completion.
//  - overrun and sat clear only on reset.
//  - Async reset mid-frame discards the partial sum. The first inReady after release
//    starts a new frame.
// CONFIGURATION
//  Macro DOTACC_SATURATE_EN:
//  - Defined: every add saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and sat<=1
//    when clipping occurs.
//  - Undefined: adds wrap modulo 2^OUT_WIDTH, and sat is constant 0.
// TESTING (LEN=4, IN_WIDTH=21, OUT_WIDTH=26 unless stated)
//  1. inData 1,2,3,4 on consecutive inReady -> outReady=1, RES=10 one cycle after the
//     4th sample; busy=1 during samples 2-4.
//  2. -5,3,-7,2 with 2-cycle gaps, then outAck -> RES=-7; outReady falls the cycle after
//     the ack.
//  3. Two back-to-back frames (1,1,1,1 then 2,2,2,2), no ack -> RES=4 then 8; overrun=1.
//     Repeat with outAck coincident with completion -> overrun=0.
//  4. Samples 5,5, then clear, then 1,2,3,4 -> RES=10. Async reset after two samples,
//     then 1,2,3,4 -> RES=10 and all flags 0.
//  5. IN_WIDTH=8, OUT_WIDTH=8, inputs 100 x4 -> with macro RES=127, sat=1; without macro
//     RES=-112, sat=0.
//  6. enable=0 for 3 cycles mid-frame, with inReady and outAck toggling -> no state change;
//     resuming 1,2,3,4 totals as if there were no stall.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums LEN partial products into one held dot-product result
//
// Purpose:
//   Consumer of the MultiplyAdd chain. Each valid partial result (inReady/inData)
//   is sign-extended and accumulated. After LEN samples the sum is presented on RES
//   with outReady held high until outAck. A result that overwrites an unacked one
//   sets the sticky overrun flag.
//
// Optional feature macro: DOTACC_SATURATE_EN
//   defined   : accumulator adds saturate; sticky sat flags any clipping
//   undefined : accumulator adds wrap modulo 2^OUT_WIDTH; sat tied to 0
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   enable    in   clock enable; low freezes all state
//   clear     in   synchronous frame abort (drops partial sum and that cycle's sample)
//   inReady   in   inData valid this cycle
//   inData    in   signed partial result, IN_WIDTH bits
//   outAck    in   consumer accepts the held result
//   outReady  out  held result valid
//   RES       out  signed dot-product result, OUT_WIDTH bits
//   busy      out  frame in progress
//   overrun   out  sticky: unacked result overwritten
//   sat       out  sticky: saturation occurred (saturating build only)

module dot_product_accumulator #(
  parameter int IN_WIDTH  = 21,
  parameter int OUT_WIDTH = 26,
  parameter int LEN       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        inReady,
  input  logic signed [IN_WIDTH-1:0]  inData,
  input  logic                        outAck,
  output logic                        outReady,
  output logic signed [OUT_WIDTH-1:0] RES,
  output logic                        busy,
  output logic                        overrun,
  output logic                        sat
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                      state;
  logic [CW-1:0]               count;
  logic signed [OUT_WIDTH-1:0] acc;

  logic signed [OUT_WIDTH-1:0] in_ext;
  logic signed [OUT_WIDTH-1:0] sum;
  logic                        clip;
  logic                        last;
  logic                        frame_done;
  logic signed [OUT_WIDTH-1:0] result;

  // Signed size cast sign-extends (also valid when OUT_WIDTH == IN_WIDTH).
  assign in_ext = OUT_WIDTH'(inData);

`ifdef DOTACC_SATURATE_EN
  localparam logic signed [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH:0] sum_wide;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign sum_wide = {acc[OUT_WIDTH-1], acc} + {in_ext[OUT_WIDTH-1], in_ext};
  assign clip     = sum_wide[OUT_WIDTH] ^ sum_wide[OUT_WIDTH-1];
  assign sum      = clip ? (sum_wide[OUT_WIDTH] ? SMIN : SMAX)
                         : sum_wide[OUT_WIDTH-1:0];
`else
  assign sum  = acc + in_ext;
  assign clip = 1'b0;
`endif

  // The first sample of a frame is a plain load; only LEN==1 completes from IDLE.
  assign last       = (state == IDLE) ? (LEN == 1) : (count == CW'(LEN - 1));
  assign frame_done = enable && inReady && !clear && last;
  assign result     = (state == IDLE) ? in_ext : sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      RES      <= '0;
      outReady <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else if (enable) begin
      // Result hand-off. A completion with a coincident ack replaces the held
      // result cleanly; without the ack the old result is lost.
      if (frame_done) begin
        RES      <= result;
        outReady <= 1'b1;
        if (outReady && !outAck) begin
          overrun <= 1'b1;
        end
      end else if (outReady && outAck) begin
        outReady <= 1'b0;
      end

      // Frame sequencing; clear outranks everything including completion.
      if (clear) begin
        state <= IDLE;
        count <= '0;
        acc   <= '0;
        busy  <= 1'b0;
      end else if (inReady) begin
        if (last) begin
          state <= IDLE;
          count <= '0;
          acc   <= '0;
          busy  <= 1'b0;
        end else if (state == IDLE) begin
          state <= ACCUM;
          count <= CW'(1);
          acc   <= in_ext;
          busy  <= 1'b1;
        end else begin
          count <= count + CW'(1);
          acc   <= sum;
        end
      end
    end
  end

`ifdef DOTACC_SATURATE_EN
  logic sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (enable && inReady && !clear && (state == ACCUM) && clip) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - scoreboard bench for dot_product_accumulator
module tb_dot_product_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               clear;
  logic               inReady;
  logic signed [20:0] inData;
  logic               outAck;
  logic               outReady;
  logic signed [25:0] RES;
  logic               busy;
  logic               overrun;
  logic               sat;

  logic               inReady8;
  logic signed [7:0]  inData8;
  logic               outReady8;
  logic signed [7:0]  RES8;
  logic               busy8;
  logic               overrun8;
  logic               sat8;

  int checks   = 0;
  int failures = 0;

  logic signed [25:0] exp_q[$];
  logic               prev_rdy = 1'b0;
  logic signed [25:0] prev_res = '0;

  always #5 clk = ~clk;

  dot_product_accumulator #(.IN_WIDTH(21), .OUT_WIDTH(26), .LEN(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .inReady(inReady), .inData(inData), .outAck(outAck),
    .outReady(outReady), .RES(RES), .busy(busy), .overrun(overrun), .sat(sat)
  );

  dot_product_accumulator #(.IN_WIDTH(8), .OUT_WIDTH(8), .LEN(4)) dut8 (
    .clk(clk), .reset(reset), .enable(1'b1), .clear(1'b0),
    .inReady(inReady8), .inData(inData8), .outAck(1'b0),
    .outReady(outReady8), .RES(RES8), .busy(busy8), .overrun(overrun8), .sat(sat8)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a new result is either outReady rising or the held RES changing.
  always @(negedge clk) begin
    if (!reset && outReady && (!prev_rdy || RES != prev_res)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got %0d expected none", RES);
      end else begin
        logic signed [25:0] e;
        e = exp_q.pop_front();
        if (RES !== e) begin
          failures++;
          $display("FAIL result: got %0d expected %0d", RES, e);
        end
      end
    end
    prev_rdy = outReady;
    prev_res = RES;
  end

  task automatic sample(input int d);
    inReady = 1'b1;
    inData  = 21'(d);
    @(posedge clk); #1;
    inReady = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    outAck = 1'b1;
    @(posedge clk); #1;
    outAck = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    inReady = 1'b0; inData = '0; outAck = 1'b0;
    inReady8 = 1'b0; inData8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_outReady", outReady, 0);
    check("rst_RES", RES, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat", sat, 0);

    // 1: consecutive 1,2,3,4
    exp_q.push_back(26'sd10);
    sample(1);
    check("t1_busy_s2", busy, 1);
    sample(2);
    check("t1_busy_s3", busy, 1);
    sample(3);
    check("t1_busy_s4", busy, 1);
    sample(4);
    check("t1_busy_done", busy, 0);
    check("t1_outReady", outReady, 1);
    wait_drain("t1");
    ack();
    check("t1_ack_clears", outReady, 0);

    // 2: gapped samples, then ack
    exp_q.push_back(-26'sd7);
    sample(-5); idle(2);
    sample(3);  idle(2);
    sample(-7); idle(2);
    sample(2);
    wait_drain("t2");
    idle(2);
    check("t2_held", outReady, 1);
    ack();
    check("t2_ack_clears", outReady, 0);
    check("t2_res_holds", RES, -7);

    // 3: back-to-back frames without ack
    exp_q.push_back(26'sd4);
    exp_q.push_back(26'sd8);
    for (int i = 0; i < 4; i++) sample(1);
    for (int i = 0; i < 4; i++) sample(2);
    wait_drain("t3");
    check("t3_overrun", overrun, 1);
    check("t3_outReady", outReady, 1);
    ack();

    // 3b: completion coincident with ack
    reset = 1'b1; #2 reset = 1'b0;
    idle(1);
    check("t3b_rst_overrun", overrun, 0);
    exp_q.push_back(26'sd4);
    exp_q.push_back(26'sd8);
    for (int i = 0; i < 4; i++) sample(1);
    for (int i = 0; i < 3; i++) sample(2);
    outAck = 1'b1;
    sample(2);
    outAck = 1'b0;
    wait_drain("t3b");
    check("t3b_outReady", outReady, 1);
    check("t3b_no_overrun", overrun, 0);
    ack();

    // 4: clear mid-frame (coincident sample dropped)
    exp_q.push_back(26'sd10);
    sample(5); sample(5);
    clear = 1'b1;
    sample(9);
    clear = 1'b0;
    check("t4_clear_busy", busy, 0);
    sample(1); sample(2); sample(3); sample(4);
    wait_drain("t4");
    ack();

    // 4b: async reset mid-frame
    sample(5); sample(5);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    idle(1);
    check("t4b_busy", busy, 0);
    exp_q.push_back(26'sd10);
    sample(1); sample(2); sample(3); sample(4);
    wait_drain("t4b");
    check("t4b_overrun", overrun, 0);
    check("t4b_sat", sat, 0);

    // 6: stall with toggling inputs while a result is pending
    sample(1); sample(2);
    for (int i = 0; i < 3; i++) begin
      enable  = 1'b0;
      inReady = 1'b1;
      inData  = 21'sd50;
      outAck  = (i % 2 == 0);
      @(posedge clk); #1;
      check("t6_stall_busy", busy, 1);
      check("t6_stall_outReady", outReady, 1);
    end
    enable = 1'b1; inReady = 1'b0; outAck = 1'b0;
    ack();
    check("t6_ack", outReady, 0);
    exp_q.push_back(26'sd10);
    sample(3); sample(4);
    wait_drain("t6");
    check("t6_overrun", overrun, 0);

    // 5: narrow instance, 100 x4
    for (int i = 0; i < 4; i++) begin
      inReady8 = 1'b1;
      inData8  = 8'sd100;
      @(posedge clk); #1;
    end
    inReady8 = 1'b0;
    check("t5_outReady", outReady8, 1);
    check("t5_busy", busy8, 0);
    check("t5_overrun", overrun8, 0);
`ifdef DOTACC_SATURATE_EN
    check("t5_RES", RES8, 127);
    check("t5_sat", sat8, 1);
`else
    check("t5_RES", RES8, -112);
    check("t5_sat", sat8, 0);
`endif

    idle(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
